axil_frame_test_sequencer: RTL
==============================

# axil_frame_test_sequencer

Synthesizable AXI4-Lite master that runs the frame-checker HLS IP in repeated runs with no testbench. Each run: program the frame count, pulse ap_start, poll ap_idle, read the error count and accumulate it. The block sits directly upstream of the checker's s_axi_control slave port and replaces the behavioural control loop in on-board bring-up builds. The running totals are exported for an ILA or VIO probe.

## Interface
Parameters:
- FRAMES_PER_RUN, 10: value written to the checker's frame-count register each run.
- NUM_RUNS, 0: number of runs before halting; 0 = run forever.
- POLL_GAP, 16: idle cycles between consecutive status polls (≥1).
- REG_CTRL, 32'h00: ap_ctrl register; bit0 ap_start, bit2 ap_idle.
- REG_ERR, 32'h10: error-count register (read).
- REG_FRAMES, 32'h20: frame-count register (write).

Ports:
- clk_0  in  1  single clock; all logic on posedge.
- rst_0  in  1  asynchronous, active-high reset.
- enable  in  1  level; sampled only in IDLE to begin the first run.
- m_axi_awaddr/awvalid/awready  out/out/in  32/1/1  write address channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arvalid/arready  out/out/in  32/1/1  read address channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel.
- acc_error_num  out  32  saturating sum of error counts.
- acc_frame_num  out  32  saturating sum of frames tested.
- run_count  out  32  completed runs.
- busy  out  1  high in any state except IDLE and HALT.
- resp_err  out  1  sticky; set on any BRESP/RRESP ≠ 2'b00.

## Operation
- States: IDLE → WR_FRAMES → WR_FRAMES_B → WR_START → WR_START_B → GAP → RD_CTRL → RD_CTRL_R → (idle bit set ? RD_ERR : GAP) → RD_ERR_R → ACCUM → (run limit reached ? HALT : WR_FRAMES).
- IDLE leaves only when enable=1. HALT is terminal until reset.
- Write phase: awvalid and wvalid rise together. Each drops in the cycle after its own ready is sampled high. When both handshakes are done, bready=1 until bvalid is sampled, then advance.
- Write data: WR_FRAMES uses addr REG_FRAMES, data FRAMES_PER_RUN, wstrb 4'b1111. WR_START uses addr REG_CTRL, data 1, wstrb 4'b0001.
- Read phase: arvalid held until arready. rready=1 from the cycle after the AR handshake until rvalid is sampled. rdata is captured in that cycle.
- GAP counts POLL_GAP cycles, then issues RD_CTRL.
- ACCUM (1 cycle):
  - acc_error_num += captured error count; acc_frame_num += FRAMES_PER_RUN. Both are 33-bit internal adds, clamped to 32'hFFFF_FFFF.
  - run_count += 1, wrapping.
- Response error: set resp_err and go to HALT immediately. The failing read's data is discarded and no accumulation occurs.
- Only one transaction is outstanding at a time. AR never overlaps AW/W.

## Timing
- Reset (async assert, sync release inside block): all valid/ready outputs 0, addr/data 0, wstrb 4'b1111, accumulators/run_count 0, resp_err 0, state IDLE.
- Reset mid-transaction drops all valids combinatorially via the async clear. The slave is expected to be reset alongside.
- Zero-wait slave run latency: IDLE→WR_FRAMES 1 cycle, each write ≥3 cycles, each read ≥3 cycles, GAP POLL_GAP cycles, ACCUM 1 cycle.
- awready and wready in the same cycle: both valids drop the next cycle; B wait starts the cycle after.
- bvalid asserted before bready: held by the slave; sampled once bready=1.

## Structure
- Package axil_seq_pkg: state enum, AXI_RESP_OKAY=2'b00, AP_IDLE_BIT=2, AP_START_BIT=0.
- One sub-module, axil_master_single: performs one read or write from req/we/addr/wdata/wstrb and returns done/rdata/err. The top FSM only sequences it.

## Test plan
- Zero-wait slave model, error register returns 3, idle after 2 polls, NUM_RUNS=2 → acc_error_num=6, acc_frame_num=20, run_count=2, HALT, busy=0.
- Random awready/wready skew (0–5 cycles each) → exactly one write per register per run; writes of 0x20←10 and 0x00←1 with wstrb 1111/0001.
- Slave returns BRESP=2'b10 on the start write → resp_err=1, HALT, no accumulation.
- Error register returns 32'hFFFF_FFF0 for 2 runs → acc_error_num saturates at 32'hFFFF_FFFF.
- rst_0 pulsed while arvalid=1 in RD_CTRL → all outputs at reset values the same cycle; restart with enable → normal run.
- enable=0 held for 100 cycles → no valid asserted, busy=0.

Source files
------------

// File: rtl/axil_frame_test_sequencer_pkg.sv
// Shared types and constants for the AXI4-Lite frame-checker test sequencer.
package axil_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_FRAMES,
    S_WR_FRAMES_B,
    S_WR_START,
    S_WR_START_B,
    S_GAP,
    S_RD_CTRL,
    S_RD_CTRL_R,
    S_RD_ERR,
    S_RD_ERR_R,
    S_ACCUM,
    S_HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WRITE,
    M_BRESP,
    M_RADDR,
    M_RDATA
  } mst_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam int unsigned AP_IDLE_BIT   = 2;
  localparam int unsigned AP_START_BIT  = 0;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/axil_frame_test_sequencer_if.sv
// AXI4-Lite bus bundle between the sequencer (master) and the checker control port (slave).
interface axil_frame_test_sequencer_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_frame_test_sequencer_master_single.sv
// Single-outstanding AXI4-Lite master: one read or write per i_req, done pulses with rdata/err.
module axil_master_single
  import axil_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  axil_frame_test_sequencer_if.master m_axi
);

  mst_state_t  r_state, w_next;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [31:0] r_awaddr, r_wdata, r_araddr, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_done, r_err;
  logic        w_aw_ok, w_w_ok;

  // AW and W complete independently; a channel whose valid already dropped counts as done.
  assign w_aw_ok = !r_awvalid || m_axi.awready;
  assign w_w_ok  = !r_wvalid  || m_axi.wready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      M_IDLE:  if (i_req) w_next = i_we ? M_WRITE : M_RADDR;
      M_WRITE: if (w_aw_ok && w_w_ok) w_next = M_BRESP;
      M_BRESP: if (m_axi.bvalid) w_next = M_IDLE;
      M_RADDR: if (m_axi.arready) w_next = M_RDATA;
      M_RDATA: if (m_axi.rvalid) w_next = M_IDLE;
      default: w_next = M_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= M_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '1;
      r_araddr  <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        M_IDLE: begin
          if (i_req && i_we) begin
            r_awaddr  <= i_addr;
            r_wdata   <= i_wdata;
            r_wstrb   <= i_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end else if (i_req) begin
            r_araddr  <= i_addr;
            r_arvalid <= 1'b1;
          end
        end
        M_WRITE: begin
          if (m_axi.awready) r_awvalid <= 1'b0;
          if (m_axi.wready)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) r_bready <= 1'b1;
        end
        M_BRESP: begin
          if (m_axi.bvalid) begin
            r_bready <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= (m_axi.bresp != AXI_RESP_OKAY);
          end
        end
        M_RADDR: begin
          if (m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        M_RDATA: begin
          if (m_axi.rvalid) begin
            r_rready <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= (m_axi.rresp != AXI_RESP_OKAY);
            if (m_axi.rresp == AXI_RESP_OKAY) r_rdata <= m_axi.rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;
  assign o_done        = r_done;
  assign o_rdata       = r_rdata;
  assign o_err         = r_err;

endmodule

// File: rtl/axil_frame_test_sequencer.sv
// Repeatedly programs, starts and polls the frame-checker IP, accumulating its error counts.
module axil_frame_test_sequencer
  import axil_seq_pkg::*;
#(
  parameter logic [31:0] FRAMES_PER_RUN = 32'd10,
  parameter logic [31:0] NUM_RUNS       = 32'd0,
  parameter int unsigned POLL_GAP       = 16,
  parameter logic [31:0] REG_CTRL       = 32'h00,
  parameter logic [31:0] REG_ERR        = 32'h10,
  parameter logic [31:0] REG_FRAMES     = 32'h20
) (
  input  logic        clk_0,
  input  logic        rst_0,
  input  logic        enable,
  axil_frame_test_sequencer_if.master m_axi,
  output logic [31:0] acc_error_num,
  output logic [31:0] acc_frame_num,
  output logic [31:0] run_count,
  output logic        busy,
  output logic        resp_err
);

  localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);
  localparam logic [31:0] START_VAL = 32'd1 << AP_START_BIT;

  seq_state_t  r_state, w_next;
  logic [1:0]  r_rst_sync;
  logic        w_rst;
  logic [31:0] r_gap_cnt, r_acc_err, r_acc_frm, r_runs;
  logic        r_resp_err;
  logic        w_req, w_we, w_done, w_err;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic [3:0]  w_wstrb;

  // Reset asserts immediately but releases two clocks after rst_0 falls.
  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) r_rst_sync <= 2'b11;
    else       r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  axil_master_single u_master (
    .i_clk   (clk_0),
    .i_rst   (w_rst),
    .i_req   (w_req),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .o_err   (w_err),
    .m_axi   (m_axi)
  );

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_wstrb = '1;
    case (r_state)
      S_IDLE: if (enable) w_next = S_WR_FRAMES;
      S_WR_FRAMES: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_FRAMES;
        w_wdata = FRAMES_PER_RUN;
        w_next  = S_WR_FRAMES_B;
      end
      S_WR_FRAMES_B: if (w_done) w_next = w_err ? S_HALT : S_WR_START;
      S_WR_START: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_CTRL;
        w_wdata = START_VAL;
        w_wstrb = 4'b0001;
        w_next  = S_WR_START_B;
      end
      S_WR_START_B: if (w_done) w_next = w_err ? S_HALT : S_GAP;
      S_GAP: if (r_gap_cnt == GAP_LAST) w_next = S_RD_CTRL;
      S_RD_CTRL: begin
        w_req  = 1'b1;
        w_addr = REG_CTRL;
        w_next = S_RD_CTRL_R;
      end
      S_RD_CTRL_R: begin
        if (w_done) begin
          if (w_err)                     w_next = S_HALT;
          else if (w_rdata[AP_IDLE_BIT]) w_next = S_RD_ERR;
          else                           w_next = S_GAP;
        end
      end
      S_RD_ERR: begin
        w_req  = 1'b1;
        w_addr = REG_ERR;
        w_next = S_RD_ERR_R;
      end
      S_RD_ERR_R: if (w_done) w_next = w_err ? S_HALT : S_ACCUM;
      S_ACCUM: w_next = (NUM_RUNS != '0 && (r_runs + 32'd1) == NUM_RUNS) ? S_HALT : S_WR_FRAMES;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or posedge w_rst) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // In ACCUM the master still holds the error count captured by the preceding read.
  always_ff @(posedge clk_0 or posedge w_rst) begin
    if (w_rst) begin
      r_gap_cnt  <= '0;
      r_acc_err  <= '0;
      r_acc_frm  <= '0;
      r_runs     <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 32'd1 : '0;
      if (w_done && w_err) r_resp_err <= 1'b1;
      if (r_state == S_ACCUM) begin
        r_acc_err <= sat_add32(r_acc_err, w_rdata);
        r_acc_frm <= sat_add32(r_acc_frm, FRAMES_PER_RUN);
        r_runs    <= r_runs + 32'd1;
      end
    end
  end

  assign acc_error_num = r_acc_err;
  assign acc_frame_num = r_acc_frm;
  assign run_count     = r_runs;
  assign resp_err      = r_resp_err;
  assign busy          = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule
